// File: rtl/bin_7segment.sv
// Scans a 16-bit value onto a 4-digit common-anode 7-segment display as hex digits.
// Latency: one cycle from `in` to seg/an. Backpressure: none; the display free-runs.
module bin_7segment #(
    parameter int unsigned DIGIT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int unsigned CNT_W = $clog2(DIGIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGIT_CYCLES - 1);

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             dp_q, dp_d;
    logic [3:0]       nibble;

    always_comb begin
        presc_d = presc_q + CNT_W'(1);
        idx_d   = idx_q;
        if (presc_q == CNT_MAX) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
    end

    // Outputs are built from the index before it advances, so an and seg
    // always describe the same digit.
    always_comb begin
        nibble = in[3:0];
        an_d   = 4'b1110;
        case (idx_q)
            2'd0: begin nibble = in[3:0];   an_d = 4'b1110; end
            2'd1: begin nibble = in[7:4];   an_d = 4'b1101; end
            2'd2: begin nibble = in[11:8];  an_d = 4'b1011; end
            2'd3: begin nibble = in[15:12]; an_d = 4'b0111; end
            default: begin nibble = in[3:0]; an_d = 4'b1110; end
        endcase
    end

    always_comb begin
        seg_d = 7'b1111111;
        case (nibble)
            4'h0: seg_d = 7'b1000000;
            4'h1: seg_d = 7'b1111001;
            4'h2: seg_d = 7'b0100100;
            4'h3: seg_d = 7'b0110000;
            4'h4: seg_d = 7'b0011001;
            4'h5: seg_d = 7'b0010010;
            4'h6: seg_d = 7'b0000010;
            4'h7: seg_d = 7'b1111000;
            4'h8: seg_d = 7'b0000000;
            4'h9: seg_d = 7'b0010000;
            4'hA: seg_d = 7'b0001000;
            4'hB: seg_d = 7'b0000011;
            4'hC: seg_d = 7'b1000110;
            4'hD: seg_d = 7'b0100001;
            4'hE: seg_d = 7'b0000110;
            4'hF: seg_d = 7'b0001110;
            default: seg_d = 7'b1111111;
        endcase
    end

    assign dp_d = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            seg_q   <= 7'b1111111;
            an_q    <= 4'b1111;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_bin_7segment.sv
module tb_bin_7segment;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_s;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: t counts non-reset edges since the last reset.
    int         t = 0;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    bin_7segment #(.DIGIT_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in_s),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] tbl [16];
        tbl[0]  = 7'b1000000; tbl[1]  = 7'b1111001; tbl[2]  = 7'b0100100; tbl[3]  = 7'b0110000;
        tbl[4]  = 7'b0011001; tbl[5]  = 7'b0010010; tbl[6]  = 7'b0000010; tbl[7]  = 7'b1111000;
        tbl[8]  = 7'b0000000; tbl[9]  = 7'b0010000; tbl[10] = 7'b0001000; tbl[11] = 7'b0000011;
        tbl[12] = 7'b1000110; tbl[13] = 7'b0100001; tbl[14] = 7'b0000110; tbl[15] = 7'b0001110;
        return tbl[v];
    endfunction

    // Predict the outputs from the inputs about to be sampled, then advance one edge.
    task automatic tick();
        int k;
        if (reset) begin
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
            t = 0;
        end else begin
            k = (t / DC) % 4;
            exp_an  = ~(4'b0001 << k);
            exp_seg = hex_seg(4'((in_s >> (4 * k)) & 16'hF));
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_s  = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an cyc %0d: got %b want 1111", i, an); end
            n_checks++;
            if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg cyc %0d: got %b want 1111111", i, seg); end
            n_checks++;
            if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp cyc %0d: got %b want 1", i, dp); end
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (an !== 4'b1110) begin n_fail++; $display("FAIL release_an: got %b want 1110", an); end
        n_checks++;
        if (seg !== 7'b0001110) begin n_fail++; $display("FAIL release_seg: got %b want 0001110", seg); end
    endtask

    task automatic test_scan();
        logic [3:0] want_an [4];
        logic [6:0] want_seg [4];
        want_an[0] = 4'b1110; want_seg[0] = 7'b0011001;
        want_an[1] = 4'b1101; want_seg[1] = 7'b0110000;
        want_an[2] = 4'b1011; want_seg[2] = 7'b0100100;
        want_an[3] = 4'b0111; want_seg[3] = 7'b1111001;
        in_s  = 16'h1234;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4 * DC + 4; i++) begin
            tick();
            n_checks++;
            if (an !== want_an[(i / DC) % 4]) begin
                n_fail++; $display("FAIL scan_an cyc %0d: got %b want %b", i, an, want_an[(i / DC) % 4]);
            end
            n_checks++;
            if (seg !== want_seg[(i / DC) % 4]) begin
                n_fail++; $display("FAIL scan_seg cyc %0d: got %b want %b", i, seg, want_seg[(i / DC) % 4]);
            end
        end
    endtask

    task automatic test_decode_sweep();
        for (int g = 0; g < 16 / DC; g++) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            for (int j = 0; j < DC; j++) begin
                in_s = {16'($urandom) & 16'hFFF0} | 16'(g * DC + j);
                tick();
                n_checks++;
                if (an !== 4'b1110) begin n_fail++; $display("FAIL sweep_an val %0d: got %b want 1110", g * DC + j, an); end
                n_checks++;
                if (seg !== hex_seg(4'(g * DC + j))) begin
                    n_fail++; $display("FAIL sweep_seg val %0d: got %b want %b", g * DC + j, seg, hex_seg(4'(g * DC + j)));
                end
            end
        end
    endtask

    task automatic test_increment();
        in_s  = 16'h0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (c > 0 && c % 20 == 0) in_s = in_s + 16'd1;
            tick();
            n_checks++;
            if ($countones(~an) != 1) begin n_fail++; $display("FAIL incr_onehot cyc %0d: an %b", c, an); end
            n_checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                n_fail++; $display("FAIL incr_out cyc %0d: got an %b seg %b want an %b seg %b", c, an, seg, exp_an, exp_seg);
            end
            if (an === 4'b1011 || an === 4'b0111) begin
                n_checks++;
                if (seg !== 7'b1000000) begin n_fail++; $display("FAIL incr_hi_zero cyc %0d: got %b want 1000000", c, seg); end
            end
        end
        n_checks++;
        if (!(exp_an == 4'b1110 && 4'(in_s) != 4'h8) && seg !== hex_seg(4'(in_s >> (4 * ((t - 1) / DC % 4))))) begin
            n_fail++; $display("FAIL incr_final: got %b", seg);
        end
    endtask

    task automatic test_random();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 120; c++) begin
            in_s = 16'($urandom);
            tick();
            n_checks++;
            if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
                n_fail++; $display("FAIL rand_out cyc %0d: got an %b seg %b dp %b want an %b seg %b dp 1", c, an, seg, dp, exp_an, exp_seg);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit found = 0;
        in_s  = 16'($urandom);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (an === 4'b1011) found = 1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL midrst_reach: an=1011 not seen in 40 cycles, last %b", an); end
        reset = 1'b1;
        tick();
        n_checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
            n_fail++; $display("FAIL midrst_vals: got an %b seg %b dp %b want 1111 1111111 1", an, seg, dp);
        end
        reset = 1'b0;
        for (int i = 0; i <= DC; i++) begin
            tick();
            n_checks++;
            if (an !== ((i < DC) ? 4'b1110 : 4'b1101)) begin
                n_fail++; $display("FAIL midrst_dwell cyc %0d: got %b want %b", i, an, (i < DC) ? 4'b1110 : 4'b1101);
            end
            n_checks++;
            if (seg !== exp_seg) begin n_fail++; $display("FAIL midrst_seg cyc %0d: got %b want %b", i, seg, exp_seg); end
        end
    endtask

    task automatic test_wrap();
        in_s  = 16'hFFFF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4 * DC; i++) begin
            tick();
            n_checks++;
            if (seg !== 7'b0001110 || dp !== 1'b1 || an !== exp_an) begin
                n_fail++; $display("FAIL wrap_f cyc %0d: got seg %b dp %b an %b want 0001110 1 %b", i, seg, dp, an, exp_an);
            end
        end
        in_s = 16'h0000;
        for (int i = 0; i < 4 * DC; i++) begin
            tick();
            n_checks++;
            if (seg !== 7'b1000000 || dp !== 1'b1 || an !== exp_an) begin
                n_fail++; $display("FAIL wrap_0 cyc %0d: got seg %b dp %b an %b want 1000000 1 %b", i, seg, dp, an, exp_an);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        in_s  = 16'h0000;
        test_reset();
        test_scan();
        test_decode_sweep();
        test_increment();
        test_random();
        test_mid_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/bin_7segment.md
Name:
bin_7segment

Overview:
- Drives a 4-digit, common-anode, multiplexed 7-segment display showing a 16-bit binary value as four hexadecimal digits.
- Sits between the counter or datapath (`in`) and the board display pins (`seg`, `an`, `dp`).
- Contains a refresh prescaler, a 2-bit digit scanner, a nibble mux and a hex-to-segment decoder. All outputs are registered.

Parameters:
- DIGIT_CYCLES, default 65536: clock cycles each digit stays enabled before the scan advances. Legal range is 2..2^24. Benches use 4.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  16  value to display; sampled every cycle, no handshake.
- seg  output  7  segment cathodes, active-low, ordered {g,f,e,d,c,b,a} (seg[0]=a).
- an  output  4  digit anodes, active-low; an[0] is the rightmost digit.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset (reset=1 at a rising edge): prescaler=0, digit index=0, an=4'b1111 (all off), seg=7'b1111111, dp=1. Reset takes priority over everything, including mid-scan.
- Prescaler: counts 0..DIGIT_CYCLES-1, then wraps to 0. On wrap the digit index increments modulo 4 (3 -> 0).
- Digit index k selects nibble in[4k+3:4k]:
  - k=0: in[3:0], an=1110
  - k=1: in[7:4], an=1101
  - k=2: in[11:8], an=1011
  - k=3: in[15:12], an=0111
- Exactly one anode is low in any non-reset cycle.
- Scan order is 1110 -> 1101 -> 1011 -> 0111 -> 1110 ...
- Each digit stays active for exactly DIGIT_CYCLES cycles; a full frame is 4*DIGIT_CYCLES cycles.
- Output registers: every cycle, an and seg are registered from the current (index, nibble) pair, so they are always mutually consistent.
- Latency:
  - A change on `in` appears on seg 1 cycle later, if its digit is active.
  - The first cycle after reset deassertion shows an=1110 and the decoded in[3:0].
- Decode table (hex digit -> seg, active-low, gfedcba): 0->1000000, 1->1111001, 2->0100100, 3->0110000, 4->0011001, 5->0010010, 6->0000010, 7->1111000, 8->0000000, 9->0010000, A->0001000, b->0000011, C->1000110, d->0100001, E->0000110, F->0001110.
- No leading-zero blanking: all four digits are always shown.
- dp is held at 1 (off) at all times.
- No input latching across a frame: digits reflect live `in`, so a value changing mid-frame may display mixed old/new nibbles. This is accepted.

Test Plan:
- Reset: assert reset for 3 cycles with in=16'hFFFF -> an=1111, seg=1111111, dp=1 throughout. After release, the next cycle gives an=1110, seg=0001110 ("F").
- Scan timing (DIGIT_CYCLES=4, in=16'h1234):
  - an follows 1110 x4, 1101 x4, 1011 x4, 0111 x4, then 1110 again.
  - seg is 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1) respectively.
- Full decode sweep: hold the scan on digit 0, step in[3:0] through 0..F one value per cycle -> seg matches every table entry with 1-cycle latency; an stays 1110.
- Incrementing input: in increments by 1 every 20 cycles from 0 for 500 cycles, DIGIT_CYCLES=4 ->
  - the digit-0 segments track the low nibble (0..0x18 by the end);
  - digits 2 and 3 show 1000000 ("0");
  - exactly one an bit is low in every post-reset cycle.
- Mid-scan reset: assert reset while an=1011 -> outputs go to reset values on the next edge. After release the scan restarts at an=1110 with the prescaler at 0, giving a full DIGIT_CYCLES dwell.
- Wrap-around: in=16'hFFFF then 16'h0000 -> all digits go from "F" (0001110) to "0" (1000000) as each digit is scanned; dp remains 1.
